// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions used by the load/store stage.
//   riscVDat     : 32-bit datapath word
//   F3_*         : func3 width/sign codes for loads and stores
//   fault_e      : completion status reported with done
//   lsu_state_e  : load/store stage sequencing states
package riscv_pkg;

  typedef logic [31:0] riscVDat;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_ILLEGAL  = 2'b10,
    FAULT_TIMEOUT  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store stage.
//   st_f3, st_off, st_data : store width code, byte offset, rs2 data
//   st_be, st_wdata        : byte enables and lane-replicated write data
//   ld_f3, ld_off, ld_raw  : load width/sign code, byte offset, raw memory word
//   ld_data                : extracted and sign/zero-extended load result
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0] st_f3,
  input  logic [1:0] st_off,
  input  riscVDat    st_data,
  output logic [3:0] st_be,
  output riscVDat    st_wdata,
  input  logic [2:0] ld_f3,
  input  logic [1:0] ld_off,
  input  riscVDat    ld_raw,
  output riscVDat    ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating the store data across all lanes lets memory pick the
  // enabled lane without needing a shifter on its side.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = st_data;
    case (st_f3)
      F3_SB: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_SH: begin
        st_be    = 4'b0011 << st_off;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (ld_off)
      2'd0: ld_byte = ld_raw[7:0];
      2'd1: ld_byte = ld_raw[15:8];
      2'd2: ld_byte = ld_raw[23:16];
      2'd3: ld_byte = ld_raw[31:24];
      default: ld_byte = ld_raw[7:0];
    endcase
    ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];

    ld_data = ld_raw;
    case (ld_f3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage: takes the ALU effective address and rs2 data on a go pulse,
// runs one word-addressed request/ack transaction to data memory and
// returns an extended load result with a completion status.
//   clk, rst                        : clock, async active-high reset
//   go, loadInstr, storeInstr, f3,
//   addr, stData                    : command, sampled only in IDLE
//   busy, done, ldData, fault       : status and load result
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata               : registered memory request
//   mem_rdata, mem_ack              : memory response
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               loadInstr,
  input  logic               storeInstr,
  input  logic [2:0]         f3,
  input  logic [D_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] stData,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] ldData,
  output logic [1:0]         fault,
  output logic               mem_req,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  input  logic               mem_ack
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e    state_q, state_d;
  fault_e        fault_d;
  logic          issue;
  logic          legal_f3;
  logic          misaligned;
  logic [CW-1:0] wait_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          load_q;
  logic [3:0]    st_be;
  riscVDat       st_wdata;
  riscVDat       ld_ext;

  lsu_align u_align (
    .st_f3    (f3),
    .st_off   (addr[1:0]),
    .st_data  (stData),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_f3    (f3_q),
    .ld_off   (off_q),
    .ld_raw   (mem_rdata),
    .ld_data  (ld_ext)
  );

  // A store flag wins over a simultaneous load flag.
  always_comb begin
    if (storeInstr)
      legal_f3 = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      legal_f3 = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
    misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                 ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    fault_d = FAULT_OK;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          if (!(loadInstr || storeInstr)) begin
            state_d = DONE;
          end else if (!legal_f3) begin
            state_d = DONE;
            fault_d = FAULT_ILLEGAL;
          end else if (misaligned) begin
            state_d = DONE;
            fault_d = FAULT_MISALIGN;
          end else begin
            state_d = REQ;
            issue   = 1'b1;
          end
        end
      end
      REQ: begin
        // Ack is checked first so an ack on the final wait cycle still succeeds.
        if (mem_ack) begin
          state_d = DONE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = DONE;
          fault_d = FAULT_TIMEOUT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      load_q    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ldData    <= '0;
      fault     <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        wait_q    <= '0;
        f3_q      <= f3;
        off_q     <= addr[1:0];
        load_q    <= loadInstr && !storeInstr;
        mem_we    <= storeInstr;
        mem_addr  <= {addr[D_WIDTH-1:2], 2'b00};
        mem_be    <= storeInstr ? st_be : 4'hF;
        mem_wdata <= storeInstr ? st_wdata : '0;
      end else if (state_q == REQ) begin
        wait_q <= wait_q + 1'b1;
      end
      if ((state_q == REQ) && mem_ack && load_q)
        ldData <= ld_ext;
      if ((state_d == DONE) && (state_q != DONE))
        fault <= fault_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign mem_req = (state_q == REQ);

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  localparam int TO    = 16;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        loadInstr;
  logic        storeInstr;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] stData;
  logic        busy;
  logic        done;
  logic [31:0] ldData;
  logic [1:0]  fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  lsu_mem_stage #(.D_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .loadInstr  (loadInstr),
    .storeInstr (storeInstr),
    .f3         (f3),
    .addr       (addr),
    .stData     (stData),
    .busy       (busy),
    .done       (done),
    .ldData     (ldData),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          has_req;
    bit          we;
    logic [31:0] maddr;
    logic [3:0]  be;
    bit          chk_wdata;
    logic [31:0] wdata;
    logic [1:0]  fault;
    logic [31:0] ld;
    int          lat;
    int          reqcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          go_cyc = 0;
  int          resp_wait = NEVER;
  logic [31:0] resp_data = '0;
  bit          force_ack = 1'b0;
  logic [31:0] ld_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ack after resp_wait un-acked request cycles; random
  // ack/rdata noise whenever no request is outstanding.
  int rcnt = 0;
  always @(negedge clk) begin
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
    end else if (mem_req && !rst) begin
      mem_ack   = (rcnt == resp_wait);
      mem_rdata = (rcnt == resp_wait) ? resp_data : $urandom;
      rcnt++;
    end else begin
      rcnt      = 0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  // Monitor: compares request fields while mem_req is up and pops the
  // scoreboard on every done pulse.
  int req_seen = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      req_seen = 0;
    end else begin
      if (mem_req) begin
        req_seen++;
        if (exp_q.size() == 0 || !exp_q[0].has_req) begin
          check("unexpected_mem_req", {31'b0, mem_req}, 32'd0);
        end else begin
          e = exp_q[0];
          check("mem_we",   {31'b0, mem_we}, {31'b0, e.we});
          check("mem_addr", mem_addr, e.maddr);
          check("mem_be",   {28'b0, mem_be}, {28'b0, e.be});
          if (e.chk_wdata) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("fault",      {30'b0, fault}, {30'b0, e.fault});
          check("ldData",     ldData, e.ld);
          check("latency",    32'(cyc - go_cyc + 1), 32'(e.lat));
          check("req_cycles", 32'(req_seen), 32'(e.reqcyc));
          check("busy_at_done", {31'b0, busy}, 32'd1);
        end
        req_seen = 0;
      end
    end
  end

  // Reference model straight from the load/store rules.
  function automatic exp_t model(input bit ld, input bit st, input logic [2:0] fc,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int w);
    exp_t        e;
    bit          legal;
    int          size;
    int          off;
    longint      mask;
    logic [31:0] v;
    e.has_req = 0; e.we = 0; e.maddr = '0; e.be = '0; e.chk_wdata = 0; e.wdata = '0;
    e.fault = 2'd0; e.ld = ld_model; e.lat = 1; e.reqcyc = 0;
    if (!ld && !st) return e;
    legal = st ? (fc <= 3'd2) : (fc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) begin
      e.fault = 2'd2;
      return e;
    end
    size = 1 << fc[1:0];
    off  = int'(a % 4);
    if ((a % size) != 0) begin
      e.fault = 2'd1;
      return e;
    end
    e.has_req = 1;
    e.we      = st;
    e.maddr   = a & ~32'd3;
    if (st) begin
      e.be        = 4'(((1 << size) - 1) << off);
      e.chk_wdata = 1;
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(sd >> (8 * (i % size)));
    end else begin
      e.be = 4'hF;
    end
    if (w < TO) begin
      e.lat    = 2 + w;
      e.reqcyc = w + 1;
      if (!st) begin
        v = rd >> (8 * off);
        if (size < 4) begin
          mask = (64'd1 << (8 * size)) - 1;
          v    = v & 32'(mask);
          if (fc < 3'd4 && ((v >> (8 * size - 1)) & 32'd1) != 0) v = v | ~32'(mask);
        end
        ld_model = v;
        e.ld     = v;
      end
    end else begin
      e.fault  = 2'd3;
      e.lat    = TO + 1;
      e.reqcyc = TO;
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input bit ld, input bit st, input logic [2:0] fc,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int w);
    int n;
    exp_q.push_back(model(ld, st, fc, a, sd, rd, w));
    resp_wait  = w;
    resp_data  = rd;
    go         = 1'b1;
    loadInstr  = ld;
    storeInstr = st;
    f3         = fc;
    addr       = a;
    stData     = sd;
    go_cyc     = cyc + 1;
    @(negedge clk);
    n = 0;
    // Junk commands while busy must be ignored.
    while (exp_q.size() != 0 && n < TO + 10) begin
      go         = 1'($urandom_range(0, 1));
      loadInstr  = 1'($urandom_range(0, 1));
      storeInstr = 1'($urandom_range(0, 1));
      f3         = 3'($urandom_range(0, 7));
      addr       = $urandom;
      stData     = $urandom;
      @(negedge clk);
      n++;
    end
    go = 1'b0;
    if (exp_q.size() != 0) begin
      check("done_wait_expired", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; go = 1'b0; loadInstr = 1'b0; storeInstr = 1'b0;
    f3 = '0; addr = '0; stData = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",      {31'b0, busy}, 32'd0);
    check("rst_done",      {31'b0, done}, 32'd0);
    check("rst_mem_req",   {31'b0, mem_req}, 32'd0);
    check("rst_mem_we",    {31'b0, mem_we}, 32'd0);
    check("rst_fault",     {30'b0, fault}, 32'd0);
    check("rst_ldData",    ldData, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    check("rst_mem_be",    {28'b0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);        // SW
    run_txn(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0);        // SB lane 3
    run_txn(1, 0, 3'b000, 32'h202, 32'h0, 32'h0080FF11, 3);        // LB -> FFFFFF80
    run_txn(1, 0, 3'b100, 32'h202, 32'h0, 32'h0080FF11, 3);        // LBU -> 00000080
    run_txn(1, 0, 3'b001, 32'h201, 32'h0, 32'h0, 0);               // LH misaligned
    run_txn(1, 0, 3'b011, 32'h200, 32'h0, 32'h0, 0);               // illegal f3
    run_txn(1, 0, 3'b010, 32'h204, 32'h0, 32'h12345678, NEVER);    // LW timeout
    run_txn(1, 0, 3'b010, 32'h208, 32'h0, 32'hCAFEF00D, TO - 1);   // ack on last cycle
    run_txn(0, 0, 3'b010, 32'h20C, 32'h0, 32'h0, 0);               // neither
    run_txn(1, 1, 3'b001, 32'h302, 32'h0000BEEF, 32'h0, 1);        // both -> SH

    // Reset while a request is outstanding.
    e = model(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, NEVER);
    exp_q.push_back(e);
    resp_wait = NEVER;
    go = 1'b1; loadInstr = 1'b1; storeInstr = 1'b0; f3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreq_rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("midreq_rst_busy",    {31'b0, busy}, 32'd0);
    check("midreq_rst_ldData",  ldData, 32'd0);
    exp_q.delete();
    ld_model = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_busy", {31'b0, busy}, 32'd0);
      check("post_rst_done", {31'b0, done}, 32'd0);
      @(negedge clk);
    end
    run_txn(1, 0, 3'b101, 32'h402, 32'h0, 32'h9abc0000, 2);        // LHU after reset

    for (int t = 0; t < 150; t++) begin
      int          kind;
      int          wsel;
      int          w;
      bit          ld;
      bit          st;
      logic [2:0]  fc;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      ld   = (kind < 5) || (kind == 9);
      st   = (kind >= 5);
      if (kind == 8) begin ld = 0; st = 0; end
      fc   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
           : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~((2'd1 << fc[1:0]) - 2'd1);
      wsel = $urandom_range(0, 9);
      if (wsel < 7)       w = wsel % 4;
      else if (wsel == 7) w = TO - 1;
      else if (wsel == 8) w = TO;
      else                w = NEVER;
      run_txn(ld, st, fc, a, $urandom, $urandom, w);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got %0d checks, expected completion", checks);
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

endmodule
